lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the RV32I execute stage and the word-organised data RAM; the RAM is the responder on the far side.
- Accepts one byte/half/word load or store per request via a valid/ready handshake.
- Converts byte addresses to word addresses, performs read-modify-write for SB/SH, and sign/zero-extends load data.
- Returns one response pulse with data or an error flag.

Parameters:
- ADDR_W, 4, word-address width of the RAM (2^ADDR_W words; default 16).
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0.

Ports:
- iClk  in  1  clock
- iRst  in  1  reset; synchronous, active-high
- iReq_Valid  in  1  request present
- oReq_Ready  out  1  block can accept a request
- iReq_WrEn  in  1  1 = store, 0 = load
- iFunct3  in  3  RV32I funct3 of the load/store
- iAddr  in  32  byte address
- iWrData  in  32  store data, right-aligned
- oRsp_Valid  out  1  one-cycle response pulse
- oRsp_RdData  out  32  extended load data; 0 for stores and errors
- oRsp_Err  out  1  misaligned, out-of-range or illegal funct3
- oMem_WrEn  out  1  RAM write strobe
- oMem_Addr  out  ADDR_W  RAM word address
- oMem_WrData  out  32  full word to write
- iMem_RdData  in  32  RAM read data, combinational from oMem_Addr

Behaviour:
- Reset:
  - State is IDLE.
  - oReq_Ready=1. oRsp_Valid, oRsp_Err, oRsp_RdData, oMem_WrEn, oMem_Addr and oMem_WrData are all 0.
  - Reset mid-operation aborts the operation with no response.
  - oMem_WrEn is gated by !iRst, so no write occurs on a reset edge.
- Handshake:
  - A request is accepted on a rising edge with iReq_Valid && oReq_Ready.
  - oReq_Ready=1 only in IDLE, so at most one request is outstanding.
  - All request fields are latched at acceptance; later input changes are ignored.
- Address:
  - offset = iAddr - BASE_ADDR; word index = offset[ADDR_W+1:2]; lane = offset[1:0].
  - Out of range when offset >= 4*2^ADDR_W (32-bit unsigned compare).
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misalignment: half with lane[0]=1, or word with lane!=0.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> RESP on accept when the request is in error (err latched; no RAM access, oMem_WrEn stays 0).
  - IDLE -> READ on accept for a load, SB or SH.
  - IDLE -> WRITE on accept for SW.
  - READ: oMem_Addr = word index; iMem_RdData is captured at the edge. Load -> RESP; SB/SH -> WRITE.
  - WRITE: oMem_WrEn=1 for exactly one cycle.
    - oMem_WrData = captured word with the addressed byte/half replaced by iWrData[7:0]/[15:0], little-endian.
    - For SW, oMem_WrData = iWrData.
    - Next state RESP.
  - RESP: oRsp_Valid=1 for one cycle, then IDLE. oRsp_RdData and oRsp_Err are registered and hold until the next RESP.
- Latency from the accept edge to oRsp_Valid high:
  - Error: 1 cycle.
  - SW: 2 cycles.
  - Load: 2 cycles.
  - SB/SH: 3 cycles.
- Load extension:
  - LB/LH sign-extend bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- oMem_Addr holds its last value outside READ/WRITE. oMem_WrData is don't-care when oMem_WrEn=0; drive 0.

Decomposition:
- Package rv32i_lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum {IDLE, READ, WRITE, RESP}.
- Sub-module lsu_byte_lane (combinational):
  - Inputs: word, lane, funct3, store data.
  - Outputs: merged store word, extended load value.
- FSM, latches and handshake stay in lsu_mem_ctrl.

Test Plan:
- SW 0xDEADBEEF @0x8, then LW @0x8 -> one-cycle oMem_WrEn with oMem_Addr=2, WrData 0xDEADBEEF; load response 0xDEADBEEF, Err=0, at 2 cycles.
- Word 2 = 0xDEADBEEF, SB 0x55 @0x9 -> READ then WRITE with WrData 0xDEAD55EF; LB @0x9 -> 0x00000055; LBU @0xB -> 0x000000DE; LB @0xB -> 0xFFFFFFDE.
- SH 0x8001 @0xA, then LH/LHU @0xA -> word 0x800155EF; LH 0xFFFF8001; LHU 0x00008001.
- Error cases, each -> Err=1 at 1 cycle, oMem_WrEn never asserted, oRsp_RdData=0:
  - LW @0x6 (misaligned).
  - SH @0x3 (misaligned).
  - LW @0x40 (out of range, ADDR_W=4).
  - funct3=011 (illegal).
- iReq_Valid held high back-to-back -> oReq_Ready low from accept until the RESP edge; the second request is accepted the cycle after oRsp_Valid; changing iAddr mid-operation has no effect.
- iRst asserted in the WRITE cycle of an SB -> no RAM write, memory unchanged, no oRsp_Valid; outputs at reset values and oReq_Ready=1 the next cycle.

Source files
------------

// File: rtl/rv32i_lsu_pkg.sv
// Shared funct3 encodings, FSM state type and request legality helper for the
// RV32I load/store unit.
package rv32i_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

   // Stores have no unsigned variants, so BU/HU are legal only for loads.
   function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !wr;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: merges store bytes/halves into a RAM word and
// extracts/extends load data from a RAM word.
module lsu_byte_lane
   import rv32i_lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] st_word_o,
   output logic [31:0] ld_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = word_i[{lane_i, 3'b000} +: 8];
      half_sel  = lane_i[1] ? word_i[31:16] : word_i[15:0];

      ld_data_o = word_i;
      case (funct3_i)
         F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ld_data_o = {24'h0, byte_sel};
         F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ld_data_o = {16'h0, half_sel};
         default: ld_data_o = word_i;
      endcase

      // Word stores pass the store data through untouched.
      st_word_o = word_i;
      case (funct3_i[1:0])
         2'b00:   st_word_o[{lane_i, 3'b000} +: 8] = st_data_i[7:0];
         2'b01: begin
            if (lane_i[1]) st_word_o[31:16] = st_data_i[15:0];
            else           st_word_o[15:0]  = st_data_i[15:0];
         end
         default: st_word_o = st_data_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator to a word-organised RAM: one request in flight,
// read-modify-write for sub-word stores, registered single-pulse response.
module lsu_mem_ctrl
   import rv32i_lsu_pkg::*;
#(
   parameter int          ADDR_W    = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iReq_Valid,
   output logic              oReq_Ready,
   input  logic              iReq_WrEn,
   input  logic [2:0]        iFunct3,
   input  logic [31:0]       iAddr,
   input  logic [31:0]       iWrData,
   output logic              oRsp_Valid,
   output logic [31:0]       oRsp_RdData,
   output logic              oRsp_Err,
   output logic              oMem_WrEn,
   output logic [ADDR_W-1:0] oMem_Addr,
   output logic [31:0]       oMem_WrData,
   input  logic [31:0]       iMem_RdData
);

   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       rsp_rd_q, rsp_rd_d;
   logic              rsp_err_q, rsp_err_d;
   logic              wr_q, wr_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       word_q, word_d;

   logic [31:0] offset;
   logic        out_of_range, misaligned, req_err;
   logic        wr_cycle;
   logic [31:0] lane_word, st_word, ld_data;

   // 33-bit compare so the RAM size limit cannot wrap for large ADDR_W.
   always_comb begin
      offset       = iAddr - BASE_ADDR;
      out_of_range = {1'b0, offset} >= (33'd1 << (ADDR_W + 2));
      case (iFunct3[1:0])
         2'b01:   misaligned = offset[0];
         2'b10:   misaligned = offset[1:0] != 2'b00;
         default: misaligned = 1'b0;
      endcase
      req_err = !f3_legal(iReq_WrEn, iFunct3) || misaligned || out_of_range;
   end

   lsu_byte_lane u_lane (
      .word_i    (lane_word),
      .lane_i    (lane_q),
      .funct3_i  (f3_q),
      .st_data_i (wdata_q),
      .st_word_o (st_word),
      .ld_data_o (ld_data)
   );

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      rsp_rd_d   = rsp_rd_q;
      rsp_err_d  = rsp_err_q;
      wr_d       = wr_q;
      f3_d       = f3_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      word_d     = word_q;
      lane_word  = word_q;
      oReq_Ready = 1'b0;
      oRsp_Valid = 1'b0;
      wr_cycle   = 1'b0;

      case (state_q)
         IDLE: begin
            oReq_Ready = 1'b1;
            if (iReq_Valid) begin
               wr_d    = iReq_WrEn;
               f3_d    = iFunct3;
               lane_d  = offset[1:0];
               wdata_d = iWrData;
               if (req_err) begin
                  rsp_err_d = 1'b1;
                  rsp_rd_d  = 32'h0;
                  state_d   = RESP;
               end else begin
                  mem_addr_d = offset[ADDR_W+1:2];
                  state_d    = (iReq_WrEn && iFunct3 == F3_W) ? WRITE : READ;
               end
            end
         end
         READ: begin
            lane_word = iMem_RdData;
            word_d    = iMem_RdData;
            if (wr_q) begin
               state_d = WRITE;
            end else begin
               rsp_rd_d  = ld_data;
               rsp_err_d = 1'b0;
               state_d   = RESP;
            end
         end
         WRITE: begin
            wr_cycle  = 1'b1;
            rsp_rd_d  = 32'h0;
            rsp_err_d = 1'b0;
            state_d   = RESP;
         end
         RESP: begin
            oRsp_Valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign oMem_WrEn   = wr_cycle && !iRst;
   assign oMem_WrData = oMem_WrEn ? st_word : 32'h0;
   assign oMem_Addr   = mem_addr_q;
   assign oRsp_RdData = rsp_rd_q;
   assign oRsp_Err    = rsp_err_q;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         rsp_rd_q   <= 32'h0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         rsp_rd_q   <= rsp_rd_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Request latches carry no reset; they are always reloaded before use.
   always_ff @(posedge iClk) begin
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
   end

endmodule
